// File: rtl/poss_pkg.sv
// Shared types and default sizing for the POSS configuration target.
package poss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } poss_state_t;

    localparam int POSS_ADDR_W = 6;
    localparam int POSS_DATA_W = 16;
    localparam int POSS_NREG   = 48;

    localparam logic [POSS_DATA_W-1:0] POSS_CSUM_INIT = '0;

endpackage

// File: rtl/poss_checksum.sv
// Running-XOR accumulator over a load cycle; match_o compares the running
// value against the word currently on din_i.
module poss_checksum
    import poss_pkg::*;
#(
    parameter int DATA_W = POSS_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              match_o
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = DATA_W'(POSS_CSUM_INIT);
        end else if (en_i) begin
            acc_d = acc_q ^ din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= DATA_W'(POSS_CSUM_INIT);
        end else begin
            acc_q <= acc_d;
        end
    end

    assign match_o = (acc_q == din_i);

endmodule

// File: rtl/poss_cfg_target.sv
// POSS loading-interface responder: stores the loader's write stream into a
// register bank and flags load completion. Optional checksum: POSS_CHECKSUM_EN.
module poss_cfg_target
    import poss_pkg::*;
#(
    parameter int ADDR_W = POSS_ADDR_W,
    parameter int DATA_W = POSS_DATA_W,
    parameter int NREG   = POSS_NREG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_data,
    input  logic                   req_last,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    input  logic                   cfg_clr,
    output logic [NREG*DATA_W-1:0] cfg_regs,
    output logic                   cfg_valid,
    output logic                   load_done,
    output logic                   load_err,
    output logic [ADDR_W:0]        wr_count
);

    localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

    poss_state_t       state_q, state_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] regs_q [NREG];

    logic accept;
    logic in_range;
    logic store;
    logic csum_word;
    logic csum_bad;

    assign req_ready = (state_q == IDLE) || (state_q == LOAD);
    // cfg_clr wins over a simultaneous write: the write is dropped unacknowledged.
    assign accept    = req_valid && req_ready && !cfg_clr;
    assign in_range  = ({1'b0, req_addr} < NREG_L);

`ifdef POSS_CHECKSUM_EN
    logic csum_match;

    assign csum_word = req_last;
    assign csum_bad  = !csum_match;

    poss_checksum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (cfg_clr),
        .en_i    (accept && !req_last),
        .din_i   (req_data),
        .match_o (csum_match)
    );
`else
    assign csum_word = 1'b0;
    assign csum_bad  = 1'b0;
`endif

    assign store = accept && in_range && !csum_word;

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        if (cfg_clr) begin
            state_d = IDLE;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            if (csum_word) begin
                rsp_err_d = csum_bad;
                state_d   = (err_q || csum_bad) ? ERROR : DONE;
            end else begin
                rsp_err_d = !in_range;
                err_d     = err_q || !in_range;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (req_last) begin
                    state_d = (err_q || !in_range) ? ERROR : DONE;
                end else begin
                    state_d = LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The bank is cleared by rst only; cfg_clr leaves stale contents in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (store) begin
            regs_q[req_addr] <= req_data;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign cfg_regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign cfg_valid = (state_q == DONE);
    assign load_done = (state_q == DONE) || (state_q == ERROR);
    assign load_err  = (state_q == ERROR);
    assign wr_count  = cnt_q;

endmodule

// File: tb/tb_poss_cfg_target.sv
// Self-checking bench for poss_cfg_target against a behavioural load model.
module tb_poss_cfg_target;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int NREG   = 48;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid = 1'b0;
    logic [ADDR_W-1:0]      req_addr = '0;
    logic [DATA_W-1:0]      req_data = '0;
    logic                   req_last = 1'b0;
    logic                   cfg_clr = 1'b0;
    logic                   req_ready, rsp_valid, rsp_err;
    logic                   cfg_valid, load_done, load_err;
    logic [NREG*DATA_W-1:0] cfg_regs;
    logic [ADDR_W:0]        wr_count;

    int vectors = 0;
    int errors  = 0;

    // Model: phase 0 = idle, 1 = loading, 2 = ended good, 3 = ended bad
    logic [DATA_W-1:0] m_regs [NREG];
    int                m_count;
    bit                m_err;
    int                m_phase;
    logic [DATA_W-1:0] m_xor;
    bit                m_rsp_v, m_rsp_e;

    poss_cfg_target dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .cfg_clr   (cfg_clr),
        .cfg_regs  (cfg_regs),
        .cfg_valid (cfg_valid),
        .load_done (load_done),
        .load_err  (load_err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t required < 2000000", $time);
        $fatal(1);
    end

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_count = 0; m_err = 0; m_phase = 0; m_xor = '0;
        m_rsp_v = 0; m_rsp_e = 0;
    endtask

    task automatic m_apply(input bit v, input int addr, input logic [DATA_W-1:0] d,
                           input bit last, input bit clr);
        m_rsp_v = 0; m_rsp_e = 0;
        if (clr) begin
            m_count = 0; m_err = 0; m_phase = 0; m_xor = '0;
            return;
        end
        if (!v || m_phase >= 2) return;
        m_rsp_v = 1;
`ifdef POSS_CHECKSUM_EN
        if (last) begin
            m_rsp_e = (d != m_xor);
            m_phase = (m_rsp_e || m_err) ? 3 : 2;
            return;
        end
`endif
        if (addr < NREG) m_regs[addr] = d;
        else begin m_err = 1; m_rsp_e = 1; end
        if (m_count < 127) m_count++;
        m_xor ^= d;
        m_phase = last ? (m_err ? 3 : 2) : 1;
    endtask

    function automatic logic [5:0] exp_flags();
        return {m_phase < 2, m_rsp_v, m_rsp_e, m_phase == 2, m_phase >= 2, m_phase == 3};
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < NREG; i++)
            if (cfg_regs[i*DATA_W +: DATA_W] !== m_regs[i]) return i;
        return -1;
    endfunction

    task automatic step(input bit v, input int addr, input logic [DATA_W-1:0] d,
                        input bit last, input bit clr);
        req_valid = v; req_addr = 6'(addr); req_data = d; req_last = last; cfg_clr = clr;
        m_apply(v, addr, d, last, clr);
        @(posedge clk); #1;
        req_valid = 0; req_last = 0; cfg_clr = 0;
    endtask

    task automatic test_reset();
        int fd;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000",
                     {req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err});
        end
        vectors++;
        if (wr_count !== 7'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", wr_count);
        end
        fd = first_diff();
        vectors++;
        if (fd != -1) begin
            errors++; $display("FAIL reset_regs: reg %0d got %h want 0", fd, cfg_regs[fd*DATA_W +: DATA_W]);
        end
        rst = 0;
    endtask

    task automatic test_normal_load();
        int fd;
        for (int i = 0; i < NREG; i++) begin
            step(1, i, 16'(i * 3), i == NREG - 1, 0);
            vectors++;
            if ({rsp_valid, rsp_err} !== {m_rsp_v, m_rsp_e}) begin
                errors++;
                $display("FAIL normal_ack[%0d]: got %b want %b", i, {rsp_valid, rsp_err}, {m_rsp_v, m_rsp_e});
            end
        end
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err} !== exp_flags()) begin
            errors++;
            $display("FAIL normal_end_flags: got %b want %b",
                     {req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err}, exp_flags());
        end
`ifndef POSS_CHECKSUM_EN
        vectors++;
        if (cfg_regs[47*DATA_W +: DATA_W] !== 16'd141 || wr_count !== 7'd48 || cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL normal_result: reg47 %0d cnt %0d valid %b want 141 48 1",
                     cfg_regs[47*DATA_W +: DATA_W], wr_count, cfg_valid);
        end
`endif
        step(0, 0, 16'h0, 0, 0);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL normal_pulse_width: rsp_valid got %b want 0", rsp_valid);
        end
        fd = first_diff();
        vectors++;
        if (fd != -1 || wr_count !== 7'(m_count)) begin
            errors++; $display("FAIL normal_bank: first bad reg %0d, cnt %0d want %0d", fd, wr_count, m_count);
        end
    endtask

    task automatic test_bad_addr();
        int fd;
        step(0, 0, 16'h0, 0, 1);
        step(1, 50, 16'hBEEF, 0, 0);
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b11) begin
            errors++; $display("FAIL bad_addr_ack: got %b want 11", {rsp_valid, rsp_err});
        end
        step(1, 0, 16'h5A5A, 1, 0);
        vectors++;
        if ({cfg_valid, load_done, load_err} !== 3'b011) begin
            errors++; $display("FAIL bad_addr_end: got %b want 011", {cfg_valid, load_done, load_err});
        end
        fd = first_diff();
        vectors++;
        if (fd != -1) begin
            errors++; $display("FAIL bad_addr_bank: reg %0d got %h want %h", fd,
                               cfg_regs[fd*DATA_W +: DATA_W], m_regs[fd]);
        end
    endtask

`ifdef POSS_CHECKSUM_EN
    task automatic test_checksum();
        step(0, 0, 16'h0, 0, 1);
        step(1, 1, 16'h1234, 0, 0);
        step(1, 2, 16'h00FF, 0, 0);
        step(1, 3, 16'h12CB, 1, 0);
        vectors++;
        if ({cfg_valid, load_err, rsp_valid, rsp_err} !== 4'b1010) begin
            errors++; $display("FAIL csum_good: got %b want 1010", {cfg_valid, load_err, rsp_valid, rsp_err});
        end
        step(0, 0, 16'h0, 0, 1);
        step(1, 1, 16'h1234, 0, 0);
        step(1, 2, 16'h00FF, 0, 0);
        step(1, 3, 16'h0000, 1, 0);
        vectors++;
        if ({cfg_valid, load_err, rsp_valid, rsp_err} !== 4'b0111) begin
            errors++; $display("FAIL csum_bad: got %b want 0111", {cfg_valid, load_err, rsp_valid, rsp_err});
        end
    endtask
`endif

    task automatic test_back_to_back();
        step(0, 0, 16'h0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (req_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, req_ready);
            end
            req_valid = 1; req_addr = 6'd5; req_data = 16'(k); req_last = 0;
            m_apply(1, 5, 16'(k), 0, 0);
            @(posedge clk); #1;
            vectors++;
            if (rsp_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_ack[%0d]: got %b want 1", k, rsp_valid);
            end
        end
        req_valid = 0;
        vectors++;
        if (cfg_regs[5*DATA_W +: DATA_W] !== 16'd4 || wr_count !== 7'd4) begin
            errors++; $display("FAIL b2b_result: reg5 %0d cnt %0d want 4 4",
                               cfg_regs[5*DATA_W +: DATA_W], wr_count);
        end
    endtask

    task automatic test_lockout_rearm();
        int fd;
        step(1, 6, m_xor, 1, 0);
        vectors++;
        if ({cfg_valid, req_ready} !== 2'b10) begin
            errors++; $display("FAIL lock_done: valid/ready got %b want 10", {cfg_valid, req_ready});
        end
        step(1, 7, 16'h7777, 0, 0);
        fd = first_diff();
        vectors++;
        if (rsp_valid !== 1'b0 || fd != -1 || wr_count !== 7'(m_count)) begin
            errors++; $display("FAIL lock_ignored: rsp %b bad reg %0d cnt %0d want 0 -1 %0d",
                               rsp_valid, fd, wr_count, m_count);
        end
        step(0, 0, 16'h0, 0, 1);
        vectors++;
        if ({cfg_valid, load_done, req_ready} !== 3'b001 || wr_count !== 7'd0) begin
            errors++; $display("FAIL rearm_clr: flags %b cnt %0d want 001 0",
                               {cfg_valid, load_done, req_ready}, wr_count);
        end
        step(1, 8, 16'hA001, 0, 0);
        step(1, 9, 16'hA002, 1'b0, 1);
        fd = first_diff();
        vectors++;
        if (rsp_valid !== 1'b0 || wr_count !== 7'd0 || fd != -1) begin
            errors++; $display("FAIL abort_drop: rsp %b cnt %0d bad reg %0d want 0 0 -1", rsp_valid, wr_count, fd);
        end
        step(1, 10, 16'hC0DE, 0, 0);
        step(1, 11, 16'hF00D, 0, 0);
        step(1, 12, 16'h1357, 0, 0);
        step(1, 13, m_xor, 1, 0);
        vectors++;
        if ({cfg_valid, load_err} !== 2'b10) begin
            errors++; $display("FAIL rearm_load: valid/err got %b want 10", {cfg_valid, load_err});
        end
    endtask

    task automatic test_saturate();
        step(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 130; i++) step(1, i % NREG, 16'($urandom), 0, 0);
        vectors++;
        if (wr_count !== 7'd127 || m_count != 127) begin
            errors++; $display("FAIL saturate: cnt %0d model %0d want 127", wr_count, m_count);
        end
    endtask

    task automatic test_random();
        int fd, addr;
        bit v, last, clr;
        logic [DATA_W-1:0] d;
        step(0, 0, 16'h0, 0, 1);
        for (int n = 0; n < 400; n++) begin
            clr  = (m_phase >= 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            v    = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 7) == 0) ? 48 + $urandom_range(0, 15) : $urandom_range(0, 47);
            last = ($urandom_range(0, 11) == 0);
            d    = 16'($urandom);
`ifdef POSS_CHECKSUM_EN
            if (last && $urandom_range(0, 1) == 1) d = m_xor;
`endif
            step(v, addr, d, last, clr);
            vectors++;
            if ({req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err} !== exp_flags()) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got %b want %b", n,
                         {req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err}, exp_flags());
            end
            vectors++;
            if (wr_count !== 7'(m_count)) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, wr_count, m_count);
            end
            fd = first_diff();
            vectors++;
            if (fd != -1) begin
                errors++; $display("FAIL rand_regs[%0d]: reg %0d got %h want %h", n, fd,
                                   cfg_regs[fd*DATA_W +: DATA_W], m_regs[fd]);
            end
        end
    endtask

    task automatic test_reset_midload();
        int fd;
        step(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, i + 20, 16'(16'h100 + i), 0, 0);
        rst = 1; req_valid = 1; req_addr = 6'd30; req_data = 16'hDEAD;
        @(posedge clk); #1;
        m_reset();
        req_valid = 0;
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err} !== 6'b100000
            || wr_count !== 7'd0) begin
            errors++;
            $display("FAIL midload_reset: flags %b cnt %0d want 100000 0",
                     {req_ready, rsp_valid, rsp_err, cfg_valid, load_done, load_err}, wr_count);
        end
        fd = first_diff();
        vectors++;
        if (fd != -1) begin
            errors++; $display("FAIL midload_regs: reg %0d got %h want 0", fd, cfg_regs[fd*DATA_W +: DATA_W]);
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_bad_addr();
`ifdef POSS_CHECKSUM_EN
        test_checksum();
`endif
        test_back_to_back();
        test_lockout_rearm();
        test_saturate();
        test_random();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
